mips_dmem_responder: RTL and testbench
======================================

// Module: mips_dmem_responder
// PURPOSE
//  Responder (target) end of the MIPS data-memory port: serves the core's memwrite/memaddr/
//  memwritedata/memreaddata interface. Contains word RAM plus a memory-mapped I/O page with a
//  free-running cycle counter, a compare timer with interrupt, and a TX FIFO drained by a
//  valid/ready stream consumer. Sits beside the core in the top level, in place of a plain dmem.
// PARAMETERS
//  DEPTH_WORDS  64      RAM size in 32-bit words; power of two
//  FIFO_DEPTH   8       TX FIFO entries; power of two, >=2
//  IO_TAG       16'hFFFF  memaddr[31:16] value selecting the I/O page; any other value selects RAM
// PORTS
//  clk           in   1   single clock, rising edge
//  reset         in   1   asynchronous, active-low reset (0 = reset asserted)
//  memwrite      in   1   write strobe from core, sampled at posedge clk
//  memaddr       in   32  byte address; bits[1:0] ignored (word access only)
//  memwritedata  in   32  write data
//  memreaddata   out  32  read data, combinational from memaddr (same-cycle read)
//  out_valid     out  1   TX FIFO head valid (= FIFO not empty)
//  out_data      out  32  TX FIFO head word
//  out_ready     in   1   consumer accepts head when out_valid & out_ready at posedge
//  irq           out  1   timer interrupt, = STATUS.timer_hit
// BEHAVIOUR
//  Reset (async, reset==0): cycle=0, timer_cmp=32'hFFFF_FFFF, timer_hit=0, overflow=0, FIFO
//   pointers/count=0 -> out_valid=0, irq=0 immediately (no clock needed). RAM is not reset.
//   Reset mid-operation discards FIFO contents; out_data is don't-care while out_valid=0.
//  RAM: index = memaddr[log2(DEPTH_WORDS)+1:2]; higher address bits alias (wrap). Write at posedge
//   when memwrite & RAM selected. Read combinational; read-during-write returns old word.
//  I/O page (memaddr[31:16]==IO_TAG), offset memaddr[15:0]:
//   0x0000 CYCLE      RO  32-bit counter, +1 every cycle, wraps FFFF_FFFF->0; writes ignored
//   0x0004 TIMER_CMP  RW  compare value
//   0x0008 STATUS     R/W1C  [0] timer_hit (W1C) [1] fifo_full [2] fifo_empty [3] overflow (W1C)
//                      [3+CW:4] fifo count, CW=log2(FIFO_DEPTH)+1; other bits read 0
//   0x000C TXDATA     WO  write pushes memwritedata into FIFO; reads return 0
//   other offsets: read 0, write ignored.
//  Timer: when cycle==timer_cmp, timer_hit=1 at next posedge (sticky). Same-cycle set and W1C: set wins.
//  FIFO push: write to TXDATA accepted if count<FIFO_DEPTH, or count==FIFO_DEPTH with pop in the
//   same cycle. Rejected push: data dropped, overflow=1 next cycle; count unchanged.
//  FIFO pop: out_valid & out_ready at posedge. Push+pop same cycle: count unchanged, both occur.
//   Pop when empty is impossible (out_valid=0); out_ready alone has no effect.
//  Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH. Latency: pushed word visible on
//   out_data/out_valid the cycle after the push edge (no bypass).
//  STATUS reflects state before the current edge; a write in cycle N is visible to reads in N+1.
// STRUCTURE
//  Shared package mips_dmem_pkg: IO_TAG default, register offsets (CYCLE/TIMER_CMP/STATUS/TXDATA),
//   STATUS bit positions. Imported here and by bench/software-image generators.
//  One sub-module: dmem_tx_fifo (params WIDTH, DEPTH; push/full/pop/empty/count, async active-low
//   reset). Decode, RAM, counter, timer, STATUS mux stay in this module.
// TESTING
//  1 RAM: write 32'hDEADBEEF @0x10, read 0x10 -> DEADBEEF; read 0x10+4*DEPTH_WORDS -> DEADBEEF (alias).
//  2 Timer: write CMP=20 after reset; irq rises the cycle after CYCLE==20; write STATUS=1 -> irq=0;
//    W1C in same cycle as match -> irq stays 1.
//  3 FIFO: out_ready=0, push 1..8 -> STATUS full=1,count=8; 9th push -> overflow=1, count 8;
//    out_ready=1 -> out_data 1..8 in order, then empty=1, out_valid=0.
//  4 Full push+pop: FIFO full, push 32'hA5 while popping -> count stays 8, A5 emerges last.
//  5 Reset mid-op: FIFO count=5, irq=1; drop reset between edges -> out_valid=0, irq=0 at once;
//    after release CYCLE reads 0-based small value, TIMER_CMP reads FFFF_FFFF, RAM unchanged.
//  6 Decode: read unmapped 0xFFFF0010 -> 0; read TXDATA -> 0; write CYCLE ignored.

Source files
------------

// File: rtl/mips_dmem_pkg.sv
// Shared constants for the MIPS data-memory responder: I/O page tag,
// register offsets and STATUS bit positions.
package mips_dmem_pkg;

    localparam logic [15:0] IO_TAG_DEFAULT = 16'hFFFF;

    localparam logic [15:0] OFS_CYCLE      = 16'h0000;
    localparam logic [15:0] OFS_TIMER_CMP  = 16'h0004;
    localparam logic [15:0] OFS_STATUS     = 16'h0008;
    localparam logic [15:0] OFS_TXDATA     = 16'h000C;

    localparam int STAT_TIMER_HIT = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 4;

    // Word-granular offset match; byte-lane bits [1:0] never take part.
    function automatic logic ofs_is(input logic [15:0] ofs, input logic [15:0] reg_ofs);
        return (ofs & 16'hFFFC) == reg_ofs;
    endfunction

endpackage

// File: rtl/dmem_tx_fifo.sv
// Circular TX FIFO with occupancy count. The caller guarantees that pop is
// only raised while non-empty and push while full only together with pop.
module dmem_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= push_data;
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign full  = (r_count == (PW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS core: word RAM plus an I/O page with a
// cycle counter, compare timer/interrupt and a stream-drained TX FIFO.
module mips_dmem_responder
    import mips_dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] IO_TAG      = IO_TAG_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   r_ram [DEPTH_WORDS];
    logic [31:0]   r_cycle;
    logic [31:0]   r_timer_cmp;
    logic          r_timer_hit;
    logic          r_overflow;

    logic          w_io_sel;
    logic [15:0]   w_ofs;
    logic [AW-1:0] w_ram_idx;
    logic          w_ram_we;
    logic          w_wr_cmp;
    logic          w_wr_status;
    logic          w_wr_tx;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [31:0]   w_head;
    logic [31:0]   w_status;

    assign w_io_sel    = (memaddr[31:16] == IO_TAG);
    assign w_ofs       = memaddr[15:0];
    assign w_ram_idx   = memaddr[AW+1:2];
    assign w_ram_we    = memwrite & ~w_io_sel;
    assign w_wr_cmp    = memwrite & w_io_sel & ofs_is(w_ofs, OFS_TIMER_CMP);
    assign w_wr_status = memwrite & w_io_sel & ofs_is(w_ofs, OFS_STATUS);
    assign w_wr_tx     = memwrite & w_io_sel & ofs_is(w_ofs, OFS_TXDATA);

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_pop  = ~w_empty & out_ready;
    assign w_push = w_wr_tx & (~w_full | w_pop);

    dmem_tx_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (w_push),
        .push_data (memwritedata),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count),
        .head      (w_head)
    );

    // Word RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) r_ram[w_ram_idx] <= memwritedata;
    end

    // Cycle counter, compare register and sticky status flags (set beats W1C).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle     <= '0;
            r_timer_cmp <= 32'hFFFF_FFFF;
            r_timer_hit <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_wr_cmp) r_timer_cmp <= memwritedata;
            if (r_cycle == r_timer_cmp)
                r_timer_hit <= 1'b1;
            else if (w_wr_status && memwritedata[STAT_TIMER_HIT])
                r_timer_hit <= 1'b0;
            if (w_wr_tx && !w_push)
                r_overflow <= 1'b1;
            else if (w_wr_status && memwritedata[STAT_OVERFLOW])
                r_overflow <= 1'b0;
        end
    end

    // STATUS word assembly; unused bits read zero.
    always_comb begin
        w_status                          = '0;
        w_status[STAT_TIMER_HIT]          = r_timer_hit;
        w_status[STAT_FULL]               = w_full;
        w_status[STAT_EMPTY]              = w_empty;
        w_status[STAT_OVERFLOW]           = r_overflow;
        w_status[STAT_COUNT_LSB +: CW]    = w_count;
    end

    // Same-cycle read mux; TXDATA and unmapped offsets read zero.
    always_comb begin
        memreaddata = '0;
        if (!w_io_sel)
            memreaddata = r_ram[w_ram_idx];
        else if (ofs_is(w_ofs, OFS_CYCLE))
            memreaddata = r_cycle;
        else if (ofs_is(w_ofs, OFS_TIMER_CMP))
            memreaddata = r_timer_cmp;
        else if (ofs_is(w_ofs, OFS_STATUS))
            memreaddata = w_status;
    end

    assign out_valid = ~w_empty;
    assign out_data  = w_head;
    assign irq       = r_timer_hit;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed plus randomized bench for mips_dmem_responder with a queue/array
// reference model stepped once per clock.
module tb_mips_dmem_responder;
    import mips_dmem_pkg::*;

    localparam int DEPTH_WORDS = 64;
    localparam int FIFO_DEPTH  = 8;
    localparam logic [31:0] IO_BASE = 32'hFFFF_0000;
    localparam logic [31:0] A_CYCLE  = IO_BASE | 32'(OFS_CYCLE);
    localparam logic [31:0] A_CMP    = IO_BASE | 32'(OFS_TIMER_CMP);
    localparam logic [31:0] A_STATUS = IO_BASE | 32'(OFS_STATUS);
    localparam logic [31:0] A_TX     = IO_BASE | 32'(OFS_TXDATA);

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        irq;

    mips_dmem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .IO_TAG      (16'hFFFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .memaddr      (memaddr),
        .memwritedata (memwritedata),
        .memreaddata  (memreaddata),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_ram    [DEPTH_WORDS];
    bit          m_ram_ok [DEPTH_WORDS];
    logic [31:0] m_cycle;
    logic [31:0] m_cmp;
    bit          m_hit;
    bit          m_ovf;
    logic [31:0] m_q [$];

    bit          lit_en;
    logic [31:0] lit_val;
    string       lit_tag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
        int unsigned idx;
        int unsigned n;
        v = 32'd0;
        if (a[31:16] != 16'hFFFF) begin
            idx = (a >> 2) % DEPTH_WORDS;
            v = m_ram[idx];
            return m_ram_ok[idx];
        end
        n = m_q.size();
        case (a[15:0] & 16'hFFFC)
            OFS_CYCLE:     v = m_cycle;
            OFS_TIMER_CMP: v = m_cmp;
            OFS_STATUS:    v = 32'(m_hit) + 2 * 32'(n == FIFO_DEPTH) + 4 * 32'(n == 0)
                             + 8 * 32'(m_ovf) + 16 * n;
            default:       v = 32'd0;
        endcase
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_cycle = 32'd0;
        m_cmp   = 32'hFFFF_FFFF;
        m_hit   = 1'b0;
        m_ovf   = 1'b0;
        m_q.delete();
    endtask

    // One bus cycle: drive at negedge, check before the edge, advance model.
    task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
        logic [31:0] mv;
        bit ok, io, is_stat, pop, push, acc, nh, no;
        memwrite = we; memaddr = a; memwritedata = wd; out_ready = rdy;
        #1;
        ok = model_read(a, mv);
        if (ok) chk("rdata", memreaddata, mv);
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
        chk("irq", 32'(irq), 32'(m_hit));
        if (lit_en) begin
            chk(lit_tag, memreaddata, lit_val);
            lit_en = 1'b0;
        end
        io      = (a[31:16] == 16'hFFFF);
        is_stat = we && io && ((a[15:0] & 16'hFFFC) == OFS_STATUS);
        pop     = rdy && (m_q.size() != 0);
        push    = we && io && ((a[15:0] & 16'hFFFC) == OFS_TXDATA);
        acc     = push && (m_q.size() < FIFO_DEPTH || pop);
        nh = (m_cycle == m_cmp) ? 1'b1 : (is_stat && wd[0]) ? 1'b0 : m_hit;
        no = (push && !acc) ? 1'b1 : (is_stat && wd[3]) ? 1'b0 : m_ovf;
        @(posedge clk);
        m_hit = nh;
        m_ovf = no;
        if (we && io && ((a[15:0] & 16'hFFFC) == OFS_TIMER_CMP)) m_cmp = wd;
        if (we && !io) begin
            m_ram[(a >> 2) % DEPTH_WORDS]    = wd;
            m_ram_ok[(a >> 2) % DEPTH_WORDS] = 1'b1;
        end
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back(wd);
        m_cycle = m_cycle + 32'd1;
        @(negedge clk);
    endtask

    task automatic rdchk(input logic [31:0] a, input logic [31:0] exp, input string tag);
        lit_en = 1'b1; lit_val = exp; lit_tag = tag;
        cyc(1'b0, a, 32'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] a, wd;
        int r;
        reset = 1'b0; memwrite = 1'b0; memaddr = '0; memwritedata = '0; out_ready = 1'b0;
        lit_en = 1'b0; lit_val = '0; lit_tag = "";
        for (int i = 0; i < DEPTH_WORDS; i++) begin m_ram_ok[i] = 1'b0; m_ram[i] = '0; end
        model_reset();
        @(negedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Timer: CMP=20 written in the first cycle after reset release.
        cyc(1'b1, A_CMP, 32'd20, 1'b0);
        for (int i = 0; i < 40 && m_cycle < 20; i++) cyc(1'b0, A_STATUS, 32'd0, 1'b0);
        chk("irq_before_match", 32'(irq), 32'd0);
        rdchk(A_CYCLE, 32'd20, "cycle_at_match");
        chk("irq_after_match", 32'(irq), 32'd1);
        cyc(1'b1, A_STATUS, 32'd1, 1'b0);
        chk("irq_w1c", 32'(irq), 32'd0);
        cyc(1'b1, A_CMP, m_cycle + 32'd2, 1'b0);
        cyc(1'b0, A_CYCLE, 32'd0, 1'b0);
        cyc(1'b1, A_STATUS, 32'd1, 1'b0);
        chk("irq_set_beats_w1c", 32'(irq), 32'd1);
        cyc(1'b1, A_STATUS, 32'd1, 1'b0);
        chk("irq_cleared", 32'(irq), 32'd0);

        // RAM write, read, alias.
        cyc(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        rdchk(32'h0000_0010, 32'hDEAD_BEEF, "ram_read");
        rdchk(32'h0000_0010 + 4 * DEPTH_WORDS, 32'hDEAD_BEEF, "ram_alias");

        // Decode.
        rdchk(IO_BASE | 32'h10, 32'd0, "unmapped_read");
        rdchk(A_TX, 32'd0, "txdata_read");
        cyc(1'b1, A_CYCLE, 32'h1234_5678, 1'b0);
        rdchk(A_CYCLE, m_cycle, "cycle_write_ignored");

        // FIFO fill, overflow, drain.
        for (int i = 1; i <= 8; i++) cyc(1'b1, A_TX, 32'(i), 1'b0);
        rdchk(A_STATUS, 32'h82, "status_full");
        cyc(1'b1, A_TX, 32'd9, 1'b0);
        rdchk(A_STATUS, 32'h8A, "status_overflow");
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", out_data, 32'(i));
            cyc(1'b0, A_STATUS, 32'd0, 1'b1);
        end
        chk("drained_valid", 32'(out_valid), 32'd0);
        rdchk(A_STATUS, 32'h0C, "status_empty");
        cyc(1'b1, A_STATUS, 32'h8, 1'b0);

        // Full FIFO push with simultaneous pop.
        for (int i = 1; i <= 8; i++) cyc(1'b1, A_TX, 32'(100 + i), 1'b0);
        cyc(1'b1, A_TX, 32'hA5, 1'b1);
        rdchk(A_STATUS, 32'h82, "full_push_pop_count");
        for (int i = 2; i <= 9; i++) begin
            chk("pushpop_order", out_data, (i == 9) ? 32'hA5 : 32'(100 + i));
            cyc(1'b0, A_CYCLE, 32'd0, 1'b1);
        end
        chk("pushpop_empty", 32'(out_valid), 32'd0);

        // Reset in the middle of operation.
        for (int i = 0; i < 5; i++) cyc(1'b1, A_TX, 32'(200 + i), 1'b0);
        cyc(1'b1, A_CMP, m_cycle + 32'd1, 1'b0);
        cyc(1'b0, A_CYCLE, 32'd0, 1'b0);
        rdchk(A_STATUS, 32'h51, "status_pre_reset");
        chk("irq_pre_reset", 32'(irq), 32'd1);
        memwrite = 1'b0;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_irq", 32'(irq), 32'd0);
        model_reset();
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        rdchk(A_CYCLE, 32'd0, "cycle_after_reset");
        rdchk(A_CMP, 32'hFFFF_FFFF, "cmp_after_reset");
        rdchk(32'h0000_0010, 32'hDEAD_BEEF, "ram_kept");

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            r  = $urandom_range(0, 9);
            wd = $urandom;
            case (r)
                0, 1, 2, 3: a = $urandom & 32'h0FFF_FFFC;
                4:          a = A_CYCLE;
                5: begin    a = A_CMP; wd = m_cycle + 32'($urandom_range(0, 6)); end
                6:          a = A_STATUS;
                7, 8:       a = A_TX;
                default:    a = IO_BASE | 32'(($urandom_range(4, 1000)) * 4);
            endcase
            cyc(1'($urandom_range(0, 1)), a, wd, 1'($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
